// File: rtl/tm1638_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tm1638_responder
//  Description : Serial responder that emulates a TM1638 LED-and-key
//                controller on the strobe/clock/open-drain-data bus. It
//                decodes commands and data into 16 display registers plus
//                display control, and returns a key-scan snapshot on reads.
//  Revision    : 1.0  initial release
// ============================================================================
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tm_strobe,
  input  logic         tm_clock,
  inout  wire          tm_dio,
  input  logic [31:0]  keys,
  output logic [127:0] display_regs,
  output logic         display_on,
  output logic [2:0]   brightness,
  output logic         frame_done,
  output logic         cmd_error
);

  // Fewer than two synchronizer flops would not be metastability safe.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_WDATA = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // --------------------------------------------------------------------------
  logic [STAGES-1:0] stb_sync_q;
  logic [STAGES-1:0] clk_sync_q;
  logic [STAGES-1:0] dio_sync_q;
  logic              stb_lvl_q, clk_lvl_q;
  logic              stb_fall_q, stb_rise_q;
  logic              clk_fall_q, clk_rise_q;
  logic              dio_bit_q;
  logic              w_stb_s, w_clk_s, w_dio_s;
  wire               w_dio_pin = tm_dio;

  assign w_stb_s = stb_sync_q[STAGES-1];
  assign w_clk_s = clk_sync_q[STAGES-1];
  assign w_dio_s = dio_sync_q[STAGES-1];

  // Bring the asynchronous bus pins into the clock domain; idle levels are high.
  always_ff @(posedge clock) begin
    if (reset) begin
      stb_sync_q <= '1;
      clk_sync_q <= '1;
      dio_sync_q <= '1;
    end else begin
      stb_sync_q <= {stb_sync_q[STAGES-2:0], tm_strobe};
      clk_sync_q <= {clk_sync_q[STAGES-2:0], tm_clock};
      dio_sync_q <= {dio_sync_q[STAGES-2:0], w_dio_pin};
    end
  end

  // Registered edge pulses; the data bit is delayed alongside so it lines up with clk_rise_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      stb_lvl_q  <= 1'b1;
      clk_lvl_q  <= 1'b1;
      stb_fall_q <= 1'b0;
      stb_rise_q <= 1'b0;
      clk_fall_q <= 1'b0;
      clk_rise_q <= 1'b0;
      dio_bit_q  <= 1'b1;
    end else begin
      stb_lvl_q  <= w_stb_s;
      clk_lvl_q  <= w_clk_s;
      stb_fall_q <= stb_lvl_q & ~w_stb_s;
      stb_rise_q <= ~stb_lvl_q & w_stb_s;
      clk_fall_q <= clk_lvl_q & ~w_clk_s;
      clk_rise_q <= ~clk_lvl_q & w_clk_s;
      dio_bit_q  <= w_dio_s;
    end
  end

  // --------------------------------------------------------------------------
  // Protocol state
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        fixed_q, fixed_d;
  logic [3:0]  addr_q, addr_d;
  logic [7:0]  regs_q [16];
  logic [7:0]  regs_d [16];
  logic        on_q, on_d;
  logic [2:0]  bright_q, bright_d;
  logic [31:0] key_sr_q, key_sr_d;
  logic [5:0]  rd_cnt_q, rd_cnt_d;
  logic        dio_low_q, dio_low_d;
  logic        frame_done_q, frame_done_d;
  logic        cmd_error_q, cmd_error_d;
  logic [7:0]  w_byte;

  // Byte as it stands once the bit arriving with this rising edge is shifted in (LSB first).
  assign w_byte = {dio_bit_q, shift_q[7:1]};

  // Next-state logic: strobe edges take priority, then per-state bit/byte handling.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    fixed_d      = fixed_q;
    addr_d       = addr_q;
    regs_d       = regs_q;
    on_d         = on_q;
    bright_d     = bright_q;
    key_sr_d     = key_sr_q;
    rd_cnt_d     = rd_cnt_q;
    dio_low_d    = dio_low_q;
    frame_done_d = 1'b0;
    cmd_error_d  = 1'b0;

    if (stb_fall_q) begin
      // New frame (or restart of the current one) always begins with a command byte.
      state_d   = S_CMD;
      bit_cnt_d = 3'd0;
      dio_low_d = 1'b0;
    end else if (stb_rise_q) begin
      // End of frame: any partial byte is dropped because bit_cnt restarts.
      if (state_q != S_IDLE) begin
        state_d      = S_IDLE;
        frame_done_d = 1'b1;
      end
      bit_cnt_d = 3'd0;
      dio_low_d = 1'b0;
    end else begin
      case (state_q)
        S_CMD, S_WDATA, S_DONE: begin
          if (clk_rise_q) begin
            shift_d   = w_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                S_CMD: begin
                  case (w_byte[7:6])
                    2'b01: begin
                      if (w_byte[1]) begin
                        key_sr_d = keys;
                        rd_cnt_d = 6'd0;
                        state_d  = S_READ;
                      end else begin
                        fixed_d = w_byte[2];
                        state_d = S_DONE;
                      end
                    end
                    2'b10: begin
                      on_d     = w_byte[3];
                      bright_d = w_byte[2:0];
                      state_d  = S_DONE;
                    end
                    2'b11: begin
                      addr_d  = w_byte[3:0];
                      state_d = S_WDATA;
                    end
                    default: begin
                      cmd_error_d = 1'b1;
                      state_d     = S_DONE;
                    end
                  endcase
                end
                S_WDATA: begin
                  regs_d[addr_q] = w_byte;
                  if (!fixed_q) begin
                    addr_d = addr_q + 4'd1;
                  end
                end
                default: begin
                  // Extra byte after a complete command.
                  cmd_error_d = 1'b1;
                end
              endcase
            end
          end
        end
        S_READ: begin
          if (clk_fall_q) begin
            if (rd_cnt_q != 6'd32) begin
              dio_low_d = ~key_sr_q[0];
              key_sr_d  = {1'b0, key_sr_q[31:1]};
              rd_cnt_d  = rd_cnt_q + 6'd1;
            end else begin
              dio_low_d = 1'b0;
            end
          end else if (clk_rise_q && (rd_cnt_q == 6'd32)) begin
            // Last bit has been sampled by the initiator; give the line back.
            dio_low_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      fixed_q      <= 1'b0;
      addr_q       <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 8'd0;
      end
      on_q         <= 1'b0;
      bright_q     <= 3'd0;
      key_sr_q     <= 32'd0;
      rd_cnt_q     <= 6'd0;
      dio_low_q    <= 1'b0;
      frame_done_q <= 1'b0;
      cmd_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      fixed_q      <= fixed_d;
      addr_q       <= addr_d;
      regs_q       <= regs_d;
      on_q         <= on_d;
      bright_q     <= bright_d;
      key_sr_q     <= key_sr_d;
      rd_cnt_q     <= rd_cnt_d;
      dio_low_q    <= dio_low_d;
      frame_done_q <= frame_done_d;
      cmd_error_q  <= cmd_error_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Open-drain: strobe rise and reset release the line without waiting a clock.
  assign tm_dio = (dio_low_q && !stb_rise_q && !reset) ? 1'b0 : 1'bz;

  for (genvar g = 0; g < 16; g++) begin : g_flat
    assign display_regs[8*g +: 8] = regs_q[g];
  end

  assign display_on = on_q;
  assign brightness = bright_q;
  assign frame_done = frame_done_q;
  assign cmd_error  = cmd_error_q;

endmodule
`default_nettype wire

// File: tb/tb_tm1638_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tm1638_responder
//  Description : Self-checking bench for tm1638_responder: directed frame
//                table, read/abort/reset sequences, and randomized frames
//                checked against a frame-level behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tm1638_responder;

  localparam int PH = 8;  // clocks per bus phase

  logic         clk = 1'b0;
  logic         reset;
  logic         tm_strobe;
  logic         tm_clock;
  logic         dio_oe;
  logic [31:0]  keys;
  logic [127:0] display_regs;
  logic         display_on;
  logic [2:0]   brightness;
  logic         frame_done;
  logic         cmd_error;
  wire          tm_dio;

  pullup (tm_dio);
  assign tm_dio = dio_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .clock        (clk),
    .reset        (reset),
    .tm_strobe    (tm_strobe),
    .tm_clock     (tm_clock),
    .tm_dio       (tm_dio),
    .keys         (keys),
    .display_regs (display_regs),
    .display_on   (display_on),
    .brightness   (brightness),
    .frame_done   (frame_done),
    .cmd_error    (cmd_error)
  );

  int fd_cnt = 0;
  int err_cnt = 0;
  always @(negedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (cmd_error)  err_cnt <= err_cnt + 1;
  end

  int tests = 0;
  int fails = 0;

  // Behavioural model of the controller at frame granularity.
  logic [7:0] m_regs [16];
  logic       m_fixed;
  logic [3:0] m_addr;
  logic       m_on;
  logic [2:0] m_br;
  int         m_fd;
  int         m_err;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_fixed = 1'b0; m_addr = 4'd0; m_on = 1'b0; m_br = 3'd0;
  endtask

  function automatic logic [127:0] m_flat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  // Apply a non-read frame's bytes to the model.
  task automatic model_frame(input logic [7:0] q[$]);
    logic [7:0] c;
    m_fd++;
    if (q.size() == 0) return;
    c = q[0];
    case (c[7:6])
      2'b00: m_err += q.size();
      2'b01: begin m_fixed = c[2]; m_err += q.size() - 1; end
      2'b10: begin m_on = c[3]; m_br = c[2:0]; m_err += q.size() - 1; end
      default: begin
        m_addr = c[3:0];
        for (int i = 1; i < q.size(); i++) begin
          m_regs[m_addr] = q[i];
          if (!m_fixed) m_addr = 4'((m_addr + 1) % 16);
        end
      end
    endcase
  endtask

  task automatic check_state(input string tag);
    check({tag, ".regs"}, display_regs, m_flat());
    check({tag, ".on"}, 128'(display_on), 128'(m_on));
    check({tag, ".bright"}, 128'(brightness), 128'(m_br));
    check({tag, ".frame_done"}, 128'(fd_cnt), 128'(m_fd));
    check({tag, ".cmd_error"}, 128'(err_cnt), 128'(m_err));
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tm_clock = 1'b0;
      dio_oe   = ~b[i];
      wait_cyc(PH);
      tm_clock = 1'b1;
      wait_cyc(PH);
    end
    dio_oe = 1'b0;
  endtask

  task automatic start_frame();
    tm_strobe = 1'b0;
    wait_cyc(PH);
  endtask

  task automatic end_frame();
    tm_strobe = 1'b1;
    wait_cyc(2 * PH);
  endtask

  task automatic write_frame(input logic [7:0] q[$]);
    start_frame();
    foreach (q[i]) send_bits(q[i], 8);
    end_frame();
    model_frame(q);
  endtask

  // Read frame: returns the 32 sampled bits and the line level after bit 31.
  task automatic read_frame(input logic [7:0] cmd, input int change_at,
                            output logic [31:0] got, output logic rel);
    start_frame();
    send_bits(cmd, 8);
    for (int i = 0; i < 32; i++) begin
      tm_clock = 1'b0;
      wait_cyc(PH);
      got[i] = tm_dio;
      if (i == change_at) keys = $urandom;
      tm_clock = 1'b1;
      wait_cyc(PH);
    end
    wait_cyc(PH);
    rel = tm_dio;
    end_frame();
    m_fd++;
  endtask

  typedef struct {
    int         n;
    logic [23:0] bytes;   // byte k at [8k+7:8k]
    int         ridx;
    logic [7:0] rval;
    logic       on;
    logic [2:0] br;
    int         derr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0]  q[$];
    logic [31:0] got, snap;
    logic        rel;
    int          fd0, err0;

    vecs[0] = '{1, 24'h000040, 0,  8'h00, 1'b0, 3'd0, 0};
    vecs[1] = '{3, 24'h063FC0, 0,  8'h3F, 1'b0, 3'd0, 0};
    vecs[2] = '{1, 24'h000044, 1,  8'h06, 1'b0, 3'd0, 0};
    vecs[3] = '{3, 24'h55AACF, 15, 8'h55, 1'b0, 3'd0, 0};
    vecs[4] = '{1, 24'h000040, 15, 8'h55, 1'b0, 3'd0, 0};
    vecs[5] = '{3, 24'h2211CF, 15, 8'h11, 1'b0, 3'd0, 0};
    vecs[6] = '{1, 24'h00008A, 0,  8'h22, 1'b1, 3'd2, 0};
    vecs[7] = '{1, 24'h000000, 0,  8'h22, 1'b1, 3'd2, 1};
    vecs[8] = '{2, 24'h001240, 1,  8'h06, 1'b1, 3'd2, 1};
    vecs[9] = '{1, 24'h000087, 15, 8'h11, 1'b0, 3'd7, 0};

    // Reset with idle bus.
    reset = 1'b1; tm_strobe = 1'b1; tm_clock = 1'b1; dio_oe = 1'b0; keys = 32'd0;
    m_fd = 0; m_err = 0;
    model_reset();
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(20);
    check("reset.dio_released", 128'(tm_dio), 128'(1'b1));
    check_state("reset");

    // Directed frame table.
    for (int v = 0; v < 10; v++) begin
      fd0 = fd_cnt; err0 = err_cnt;
      q.delete();
      for (int k = 0; k < vecs[v].n; k++) q.push_back(vecs[v].bytes[8*k +: 8]);
      write_frame(q);
      check($sformatf("vec%0d.reg", v), 128'(display_regs[8*vecs[v].ridx +: 8]), 128'(vecs[v].rval));
      check($sformatf("vec%0d.on", v), 128'(display_on), 128'(vecs[v].on));
      check($sformatf("vec%0d.bright", v), 128'(brightness), 128'(vecs[v].br));
      check($sformatf("vec%0d.err_pulses", v), 128'(err_cnt - err0), 128'(vecs[v].derr));
      check($sformatf("vec%0d.done_pulses", v), 128'(fd_cnt - fd0), 128'(1));
      check_state($sformatf("vec%0d", v));
    end

    // Key read with keys changing mid-frame.
    keys = 32'h8040_2001;
    read_frame(8'h42, 12, got, rel);
    check("read.bytes", 128'(got), 128'(32'h8040_2001));
    check("read.released", 128'(rel), 128'(1'b1));
    keys = 32'h0000_0000;
    read_frame(8'h42, 40, got, rel);
    check("read_zero.bytes", 128'(got), 128'(32'h0));
    check("read_zero.released", 128'(rel), 128'(1'b1));
    check_state("read");

    // Abort after 5 bits of a data byte: no write to reg3.
    start_frame();
    send_bits(8'hC3, 8);
    send_bits(8'h00, 5);
    end_frame();
    q.delete(); q.push_back(8'hC3);
    model_frame(q);
    check("abort.reg3", 128'(display_regs[31:24]), 128'(8'h00));
    check_state("abort");

    // Reset in the middle of a read.
    keys = 32'h0;
    start_frame();
    send_bits(8'h42, 8);
    for (int i = 0; i < 4; i++) begin
      tm_clock = 1'b0; wait_cyc(PH); tm_clock = 1'b1; wait_cyc(PH);
    end
    tm_clock = 1'b0;
    wait_cyc(PH);
    check("rst_read.driving", 128'(tm_dio), 128'(1'b0));
    reset = 1'b1;
    #1;
    check("rst_read.released", 128'(tm_dio), 128'(1'b1));
    tm_strobe = 1'b1; tm_clock = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(3 * PH);
    model_reset();
    check("rst_read.dio", 128'(tm_dio), 128'(1'b1));
    check_state("rst_read");
    q.delete(); q.push_back(8'h8A);
    write_frame(q);
    check_state("post_reset");

    // Randomized frames against the model.
    for (int it = 0; it < 40; it++) begin
      logic [7:0] cmd;
      case ($urandom_range(0, 3))
        0: cmd = 8'($urandom);
        1: cmd = 8'hC0 | 8'($urandom_range(0, 15));
        2: cmd = 8'h40 | (8'($urandom) & 8'h06);
        default: cmd = 8'h80 | 8'($urandom_range(0, 15));
      endcase
      if (cmd[7:6] == 2'b01 && cmd[1]) begin
        keys = $urandom;
        snap = keys;
        read_frame(cmd, $urandom_range(0, 31), got, rel);
        check($sformatf("rnd%0d.read", it), 128'(got), 128'(snap));
        check($sformatf("rnd%0d.released", it), 128'(rel), 128'(1'b1));
      end else begin
        q.delete();
        q.push_back(cmd);
        for (int k = 0; k < $urandom_range(0, 4); k++) q.push_back(8'($urandom));
        write_frame(q);
      end
      check_state($sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
